seg7_scan_ctrl: RTL

//  Parametrised multiplexed 7-segment scan controller; next generation of the 4-digit board mux.

---
 rtl/seg7_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Multiplexed 7-segment scan controller. NUM_DIGITS hex digits share one
// segment bus. Each digit owns the bus for REFRESH_CYCLES clocks in turn.
// The built-in hex decoder drives the bus. The block also handles per-digit
// decimal points, per-digit blanking, leading-zero suppression and 16-level
// PWM brightness.
//
// Parameters
//   NUM_DIGITS      digits scanned (2..8)
//   REFRESH_CYCLES  clk cycles per digit slot (>= 16)
//   AN_ACTIVE_LOW   1: selected anode driven 0, 0: selected anode driven 1
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits      hex nibbles, digit i = digits[4*i+3:4*i], digit 0 rightmost
//   dp_in       decimal point request per digit, 1 = lit
//   blank       force digit dark (segments and dp), 1 = blank
//   lz_en       leading-zero suppression enable
//   disp_en     0 = all anodes inactive
//   brightness  PWM on-time (brightness+1)/16 within a slot
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low
//   an          anode enables, polarity per AN_ACTIVE_LOW
//   scan_tick   one-cycle pulse when the scan index advances
//
// All outputs are registered. They reflect the scan index and the inputs
// sampled on the previous clock, so any input change reaches the pins one
// cycle later.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic                      lz_en,
    input  logic                      disp_en,
    input  logic [3:0]                brightness,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      scan_tick
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_CYCLES);

    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(REFRESH_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF   = 7'h7F;

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [3:0]            pwm_cnt;

    logic                  slot_last;
    logic [NUM_DIGITS-1:0] dark_vec;
    logic                  zero_run;
    logic [3:0]            cur_nibble;
    logic [6:0]            hex_seg;
    logic                  an_on;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [NUM_DIGITS-1:0] an_sel;

    // Active-low gfedcba patterns for 0..F.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    assign slot_last = (slot_cnt == SLOT_LAST);

    // Walk from the most significant digit downwards. zero_run stays set while
    // every digit seen so far is zero, and those digits are the leading zeros.
    // Digit 0 is never suppressed, so an all-zero value still shows "0".
    always_comb begin
        // NOTE: every variable gets a default before any conditional logic, so
        // no path leaves it unassigned and no latch is inferred.
        zero_run = 1'b1;
        dark_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (digits[4*i +: 4] == 4'h0);
            dark_vec[i] = blank[i] | (lz_en & (i != 0) & zero_run);
        end
    end

    assign cur_nibble = digits[{scan_idx, 2'b00} +: 4];
    assign hex_seg    = hex_decode(cur_nibble);
    assign an_on      = disp_en & (pwm_cnt <= brightness) & ~dark_vec[scan_idx];
    assign an_onehot  = NUM_DIGITS'(1) << scan_idx;
    assign an_sel     = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            scan_idx  <= '0;
            pwm_cnt   <= '0;
            seg       <= SEG_OFF;
            dp_n      <= 1'b1;
            an        <= AN_OFF;
            scan_tick <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every right-hand
            // side below sees the pre-edge values of the counters.
            pwm_cnt   <= pwm_cnt + 4'd1;
            scan_tick <= slot_last;
            if (slot_last) begin
                slot_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
            // Segments and dp are forced dark whenever the anode is off. This
            // stops the previous digit from ghosting into the next slot.
            seg  <= an_on ? hex_seg : SEG_OFF;
            dp_n <= an_on ? ~dp_in[scan_idx] : 1'b1;
            an   <= an_on ? an_sel : AN_OFF;
        end
    end

endmodule
